// File: rtl/my_pkg.sv
// my_pkg: shared widths, the NOP encoding and the fetch-state type for the
// instruction-fetch stage.
//   ADDR_WIDTH / DATA_WIDTH : address and instruction widths
//   NOP_INST                : value presented in an empty IF/ID slot after reset
//   fetch_state_e           : BOOT / RUN / HALT
package my_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: the IF/ID pipeline slot (valid / pc / inst).
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture pc_in/inst_in and mark the slot valid
//   flush           : clear valid; takes priority over load
//   pc_in, inst_in  : values captured on load
//   if_valid, if_pc, if_inst : slot contents
// With neither load nor flush the slot holds (stall).
module if_id_reg
    import my_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] inst_in,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_inst
);

    logic                  valid_d, valid_q;
    logic [ADDR_WIDTH-1:0] pc_d,    pc_q;
    logic [DATA_WIDTH-1:0] inst_d,  inst_q;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush) begin
            // pc/inst are left as they are; only valid matters downstream
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            inst_d  = inst_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign if_valid = valid_q;
    assign if_pc    = pc_q;
    assign if_inst  = inst_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with PC register, fetch FSM and IF/ID slot.
//   clk, rst                    : clock, synchronous active-high reset
//   redirect_valid, redirect_pc : taken branch / jump target from EX
//   id_ready                    : ID accepts the slot this cycle
//   imem_addr, imem_inst        : combinational instruction-memory port
//   if_valid, if_pc, if_inst    : IF/ID slot
//   fetch_fault                 : misaligned redirect trapped (sticky until reset)
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect halts fetch and raises fetch_fault
//   undefined : redirect_pc[1:0] is forced to 0, HALT is unreachable,
//               fetch_fault is tied to 0
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle after reset; no capture, redirect still honoured
// RUN   | normal fetch: capture into a free slot, advance PC by 4
// HALT  | fetch frozen after a trapped misaligned redirect; only rst exits
module if_stage
    import my_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_inst,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_inst,
    output logic                  fetch_fault
);

    fetch_state_e          state_d, state_q;
    logic [ADDR_WIDTH-1:0] pc_d,    pc_q;
    logic                  slot_load;
    logic                  slot_flush;
    logic                  slot_free;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

`ifdef IF_MISALIGN_TRAP_EN
    logic fault_d, fault_q;
    logic misaligned;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
`endif

    assign slot_free        = ~if_valid | id_ready;
    assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(3);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        slot_load  = 1'b0;
        slot_flush = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            BOOT, RUN: begin
                if (state_q == BOOT) begin
                    state_d = RUN;
                end
                if (redirect_valid) begin
                    // the instruction fetched this cycle is dropped
                    slot_flush = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_pc;
                    end
`else
                    pc_d = redirect_aligned;
`endif
                end else if (state_q == RUN && slot_free) begin
                    slot_load = 1'b1;
                    pc_d      = pc_q + ADDR_WIDTH'(4);
                end
            end
            HALT: begin
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign imem_addr = pc_q;

`ifdef IF_MISALIGN_TRAP_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    if_id_reg #(
        .RESET_PC (RESET_PC)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (slot_load),
        .flush    (slot_flush),
        .pc_in    (pc_q),
        .inst_in  (imem_inst),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst)
    );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table, hand-written misaligned
// redirect sequence, then randomized traffic against a behavioural model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic [31:0] imem_addr,   imem_inst;
    logic        if_valid,    fetch_fault;
    logic [31:0] if_pc,       if_inst;

    logic [31:0] w_imem_addr, w_imem_inst;
    logic        w_if_valid,  w_fetch_fault;
    logic [31:0] w_if_pc,     w_if_inst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // instruction memory: address-derived pattern, zero on one word per 128 B
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a[6:2] == 5'h1F) return 32'h0;
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_inst   = mem(imem_addr);
    assign w_imem_inst = mem(w_imem_addr);

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_ready(id_ready),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .fetch_fault(fetch_fault)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_ready(id_ready),
        .imem_addr(w_imem_addr), .imem_inst(w_imem_inst),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_inst(w_if_inst),
        .fetch_fault(w_fetch_fault)
    );

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic        chk_slot;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
        logic        w_chk;
        logic [31:0] w_pc;
    } vec_t;

    function automatic vec_t v(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic ev, input logic chk,
                               input logic [31:0] epc, input logic [31:0] eaddr);
        vec_t x;
        x.rst = r; x.rv = rv; x.rpc = rpc; x.rdy = rdy;
        x.e_valid = ev; x.chk_slot = chk; x.e_pc = epc; x.e_addr = eaddr;
        x.e_inst = ev ? mem(epc) : NOP;
        x.w_chk = 1'b0; x.w_pc = 32'h0;
        return x;
    endfunction

    // behavioural reference model (mode: 0 boot, 1 run, 2 halt)
    int          m_mode;
    logic [31:0] m_pc, m_spc, m_sinst;
    logic        m_valid, m_fault;

    task automatic model_step(input logic r, input logic rv,
                              input logic [31:0] rpc, input logic rdy);
        logic was_run;
        if (r) begin
            m_mode = 0; m_pc = 32'h0; m_valid = 1'b0;
            m_spc = 32'h0; m_sinst = NOP; m_fault = 1'b0;
        end else if (m_mode != 2) begin
            was_run = (m_mode == 1);
            m_mode  = 1;
            if (rv) begin
                m_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
                if (rpc % 4 != 0) begin
                    m_mode  = 2;
                    m_fault = 1'b1;
                end else begin
                    m_pc = rpc;
                end
`else
                m_pc = rpc - (rpc % 4);
`endif
            end else if (was_run && (!m_valid || rdy)) begin
                m_spc   = m_pc;
                m_sinst = mem(m_pc);
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    vec_t tbl[18];

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;

        //          rst rv  rpc           rdy ev  chk  e_pc          e_addr
        tbl[0]  = v(1, 0, 32'h0,       1, 0, 1, 32'h0,       32'h0);
        tbl[1]  = v(1, 0, 32'h0,       1, 0, 1, 32'h0,       32'h0);
        tbl[2]  = v(0, 0, 32'h0,       1, 0, 1, 32'h0,       32'h0);
        tbl[3]  = v(0, 0, 32'h0,       1, 1, 1, 32'h0,       32'h4);
        tbl[4]  = v(0, 0, 32'h0,       1, 1, 1, 32'h4,       32'h8);
        tbl[5]  = v(0, 0, 32'h0,       1, 1, 1, 32'h8,       32'hC);
        tbl[6]  = v(0, 0, 32'h0,       0, 1, 1, 32'h8,       32'hC);
        tbl[7]  = v(0, 0, 32'h0,       0, 1, 1, 32'h8,       32'hC);
        tbl[8]  = v(0, 0, 32'h0,       0, 1, 1, 32'h8,       32'hC);
        tbl[9]  = v(0, 0, 32'h0,       1, 1, 1, 32'hC,       32'h10);
        tbl[10] = v(0, 1, 32'h100,     0, 0, 0, 32'h0,       32'h100);
        tbl[11] = v(0, 0, 32'h0,       0, 1, 1, 32'h100,     32'h104);
        tbl[12] = v(0, 0, 32'h0,       0, 1, 1, 32'h100,     32'h104);
        tbl[13] = v(1, 0, 32'h0,       0, 0, 1, 32'h0,       32'h0);
        tbl[14] = v(0, 1, 32'h200,     1, 0, 0, 32'h0,       32'h200);
        tbl[15] = v(0, 0, 32'h0,       1, 1, 1, 32'h200,     32'h204);
        tbl[16] = v(0, 1, 32'h7C,      1, 0, 0, 32'h0,       32'h7C);
        tbl[17] = v(0, 0, 32'h0,       1, 1, 1, 32'h7C,      32'h80);
        tbl[3].w_chk = 1'b1; tbl[3].w_pc = 32'hFFFF_FFF8;
        tbl[4].w_chk = 1'b1; tbl[4].w_pc = 32'hFFFF_FFFC;
        tbl[5].w_chk = 1'b1; tbl[5].w_pc = 32'h0000_0000;

        #2;
        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rpc; id_ready = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d if_valid", i), if_valid == tbl[i].e_valid,
                  {31'h0, if_valid}, {31'h0, tbl[i].e_valid});
            check($sformatf("vec%0d imem_addr", i), imem_addr == tbl[i].e_addr,
                  imem_addr, tbl[i].e_addr);
            check($sformatf("vec%0d fetch_fault", i), fetch_fault == 1'b0,
                  {31'h0, fetch_fault}, 32'h0);
            if (tbl[i].chk_slot) begin
                check($sformatf("vec%0d if_pc", i), if_pc == tbl[i].e_pc,
                      if_pc, tbl[i].e_pc);
                check($sformatf("vec%0d if_inst", i), if_inst == tbl[i].e_inst,
                      if_inst, tbl[i].e_inst);
            end
            if (tbl[i].w_chk) begin
                check($sformatf("vec%0d wrap if_pc", i),
                      w_if_valid && !w_fetch_fault && w_if_pc == tbl[i].w_pc,
                      w_if_pc, tbl[i].w_pc);
                check($sformatf("vec%0d wrap if_inst", i), w_if_inst == mem(tbl[i].w_pc),
                      w_if_inst, mem(tbl[i].w_pc));
            end
        end

        // misaligned redirect while fetching at 0x80
        redirect_valid = 1'b1; redirect_pc = 32'h102; id_ready = 1'b1;
        tick();
`ifdef IF_MISALIGN_TRAP_EN
        redirect_pc = 32'h300;
        for (int k = 0; k < 11; k++) begin
            check($sformatf("trap%0d fault", k), fetch_fault == 1'b1,
                  {31'h0, fetch_fault}, 32'h1);
            check($sformatf("trap%0d valid", k), if_valid == 1'b0,
                  {31'h0, if_valid}, 32'h0);
            check($sformatf("trap%0d imem_addr", k), imem_addr == 32'h80,
                  imem_addr, 32'h80);
            redirect_valid = k[0];
            tick();
        end
`else
        check("misalign imem_addr", imem_addr == 32'h100, imem_addr, 32'h100);
        check("misalign fault", fetch_fault == 1'b0, {31'h0, fetch_fault}, 32'h0);
        check("misalign valid", if_valid == 1'b0, {31'h0, if_valid}, 32'h0);
        redirect_valid = 1'b0;
        tick();
        check("misalign next if_pc", if_valid && if_pc == 32'h100, if_pc, 32'h100);
        check("misalign next fault", fetch_fault == 1'b0, {31'h0, fetch_fault}, 32'h0);
`endif

        // randomized traffic against the model
        redirect_valid = 1'b0;
        for (int c = 0; c < 800; c++) begin
            logic        r, rv, rdy;
            logic [31:0] rpc;
            r   = (c < 2) || ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rpc = $urandom & 32'h0000_03FC;
            if ($urandom_range(0, 15) == 0) rpc = rpc | 32'h2;
            rdy = ($urandom_range(0, 3) != 0);
            rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
            model_step(r, rv, rpc, rdy);
            tick();
            check($sformatf("rnd%0d state", c),
                  if_valid == m_valid && imem_addr == m_pc && fetch_fault == m_fault,
                  {imem_addr[29:0], if_valid, fetch_fault},
                  {m_pc[29:0], m_valid, m_fault});
            if (m_valid) begin
                check($sformatf("rnd%0d slot", c),
                      if_pc == m_spc && if_inst == m_sinst, if_pc, m_spc);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
